// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - branch redirect, load-use stall and perf counters for the 5-stage MIPS core
//
// Purpose:
//   Takes the resolved EX-stage branch decision and issues the PC redirect and
//   wrong-path flushes one cycle later. Inserts the single load-use stall a
//   branch in ID needs when the load directly ahead of it (in EX) writes one
//   of its operands. Keeps saturating branch / taken / stall counters.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_branch, id_rs, id_rt   branch flag and source registers of the ID instruction
//   ex_mem_read, ex_rd        load flag and destination register of the EX instruction
//   ex_branch, ex_taken       branch flag and resolved condition of the EX instruction
//   ex_target                 branch target computed in EX
//   pc_write, ifid_write      PC / IF-ID write enables (low during a stall)
//   ifid_flush, idex_flush,
//   exmem_flush               bubble insertion into each pipeline register
//   pc_redirect, redirect_pc  next-PC select and registered branch target
//   branch_cnt, taken_cnt,
//   stall_cnt                 saturating performance counters

module hz_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    // Hold at all-ones instead of wrapping back to zero.
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The counter reads as zero for the whole reset cycle, not only after the edge.
  assign count_o = rst_i ? '0 : count_q;

endmodule

module branch_hazard_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_branch,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              ex_branch,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   redirect_q;
  logic [ADDR_W-1:0]   redirect_d;

  logic                hz;
  logic                tk;
  logic                count_en;
  logic                branch_inc;
  logic                taken_inc;
  logic                stall_inc;

  // Load in EX feeds a register the branch in ID reads; $0 never carries a dependency.
  assign hz = id_branch & ex_mem_read & (ex_rd != 5'd0) &
              ((ex_rd == id_rs) | (ex_rd == id_rt));

  // Only a definite 1 counts as taken; an unknown condition must not redirect.
  assign tk = ex_branch & (ex_taken === 1'b1);

  // During REDIRECT the EX branch is itself wrong-path and must not be counted.
  assign count_en = (state_q == IDLE) || (state_q == STALL);

  always_comb begin
    state_d     = state_q;
    redirect_d  = redirect_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_redirect = 1'b0;
    stall_inc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (tk) begin
          // A taken branch squashes the branch in ID, so any hazard it has is moot.
          redirect_d = ex_target;
          state_d    = REDIRECT;
        end else if (hz) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
          state_d    = STALL;
        end
      end

      STALL: begin
        // The load has moved on; hz may still read high but no second bubble is due.
        if (tk) begin
          redirect_d = ex_target;
          state_d    = REDIRECT;
        end else begin
          state_d = IDLE;
        end
      end

      REDIRECT: begin
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset overrides everything: outputs look like normal flow, nothing pending.
    if (rst) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      pc_redirect = 1'b0;
      stall_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
    end
  end

  assign redirect_pc = rst ? '0 : redirect_q;

  assign branch_inc = count_en & ex_branch;
  assign taken_inc  = count_en & tk;

  hz_sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (branch_inc),
    .count_o (branch_cnt)
  );

  hz_sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (taken_inc),
    .count_o (taken_cnt)
  );

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (stall_inc),
    .count_o (stall_cnt)
  );

endmodule
